fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_controller.sv | 99 +++++++++
 tb/tb_fetch_controller.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch controller: state encoding and
// default memory-map constants.
package fetch_pkg;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_t;

   localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0040_0000;
   localparam logic [31:0] DEFAULT_IMEM_BASE  = 32'h0040_0000;
   localparam int          DEFAULT_IMEM_WORDS = 256;

endpackage

// File: rtl/fetch_controller.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory and loads
// the IF/ID register, with redirect, stall and a sticky fault/halt on bad fetches.
module fetch_controller
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter logic [31:0] IMEM_BASE  = DEFAULT_IMEM_BASE,
   parameter int          IMEM_WORDS = DEFAULT_IMEM_WORDS
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4,
   output logic [31:0] if_instr,
   output logic        fetch_fault,
   output logic [31:0] fetch_count
);

   localparam logic [31:0] IMEM_LAST = IMEM_BASE + 32'(4 * (IMEM_WORDS - 1));

   function automatic logic pc_is_legal(input logic [31:0] pc);
      return (pc[1:0] == 2'b00) && (pc >= IMEM_BASE) && (pc <= IMEM_LAST);
   endfunction

   fetch_state_t r_state;
   logic [31:0]  r_pc;
   logic         r_if_valid;
   logic [31:0]  r_if_pc;
   logic [31:0]  r_if_pc_plus4;
   logic [31:0]  r_if_instr;
   logic         r_fetch_fault;
   logic [31:0]  r_fetch_count;

   logic         w_pc_legal;
   logic [31:0]  w_pc_plus4;

   assign w_pc_legal = pc_is_legal(r_pc);
   assign w_pc_plus4 = r_pc + 32'd4;

   // Redirect targets are deliberately not checked here; a bad target is
   // caught on the next cycle when it becomes the fetch address.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= RUN;
         r_pc          <= RESET_PC;
         r_if_valid    <= 1'b0;
         r_if_pc       <= 32'd0;
         r_if_pc_plus4 <= 32'd0;
         r_if_instr    <= 32'd0;
         r_fetch_fault <= 1'b0;
         r_fetch_count <= 32'd0;
      end else if (redirect_valid) begin
         r_state       <= RUN;
         r_pc          <= redirect_target;
         r_if_valid    <= 1'b0;
         r_if_instr    <= 32'd0;
         r_fetch_fault <= 1'b0;
      end else begin
         case (r_state)
            HALTED: begin
               r_if_valid    <= 1'b0;
               r_fetch_fault <= 1'b1;
            end
            default: begin
               if (stall) begin
                  r_state <= RUN;
               end else if (!w_pc_legal) begin
                  r_state       <= HALTED;
                  r_fetch_fault <= 1'b1;
                  r_if_valid    <= 1'b0;
                  r_if_instr    <= 32'd0;
               end else begin
                  r_if_instr    <= imem_instr;
                  r_if_pc       <= r_pc;
                  r_if_pc_plus4 <= w_pc_plus4;
                  r_if_valid    <= 1'b1;
                  r_pc          <= w_pc_plus4;
                  r_fetch_count <= r_fetch_count + 32'd1;
               end
            end
         endcase
      end
   end

   assign imem_addr   = r_pc;
   assign if_valid    = r_if_valid;
   assign if_pc       = r_if_pc;
   assign if_pc_plus4 = r_if_pc_plus4;
   assign if_instr    = r_if_instr;
   assign fetch_fault = r_fetch_fault;
   assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios plus random stall/redirect/reset
// traffic, checked per cycle and through a delivered-instruction scoreboard.
module tb_fetch_controller;

   localparam logic [31:0] BASE  = 32'h0040_0000;
   localparam int          WORDS = 256;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = 32'd0;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic [31:0] if_instr;
   logic        fetch_fault;
   logic [31:0] fetch_count;

   always #5 clk = ~clk;

   // Memory stub: every word reads back as the inverted address.
   assign imem_instr = imem_addr ^ 32'hFFFF_FFFF;

   fetch_controller dut (
      .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
      .stall(stall), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .if_valid(if_valid), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .if_instr(if_instr),
      .fetch_fault(fetch_fault), .fetch_count(fetch_count)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] count;
   } fetch_rec_t;

   fetch_rec_t exp_q[$];
   int checks = 0;
   int errors = 0;

   // Reference state, in architectural terms.
   logic [31:0] m_pc = BASE;
   logic        m_halted = 1'b0;
   logic        m_fault = 1'b0;
   logic        m_valid = 1'b0;
   logic [31:0] m_count = 32'd0;
   logic [31:0] m_if_pc = 32'd0;
   logic [31:0] m_if_pc4 = 32'd0;
   logic [31:0] m_if_instr = 32'd0;

   function automatic logic legal(input logic [31:0] a);
      longint off;
      off = longint'(a) - longint'(BASE);
      return (a % 4 == 0) && off >= 0 && (off / 4) < WORDS;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
      end
   endtask

   task automatic step(input logic rst, input logic st, input logic rv, input logic [31:0] tgt);
      reset = rst;
      stall = st;
      redirect_valid = rv;
      redirect_target = tgt;
      if (rst) begin
         m_pc = BASE; m_halted = 0; m_fault = 0; m_valid = 0; m_count = 0;
         m_if_pc = 0; m_if_pc4 = 0; m_if_instr = 0;
      end else if (rv) begin
         m_pc = tgt; m_halted = 0; m_fault = 0; m_valid = 0; m_if_instr = 0;
      end else if (m_halted || st) begin
         // nothing moves
      end else if (!legal(m_pc)) begin
         m_halted = 1; m_fault = 1; m_valid = 0; m_if_instr = 0;
      end else begin
         m_count = m_count + 1;
         exp_q.push_back('{pc: m_pc, instr: ~m_pc, count: m_count});
         m_if_pc = m_pc; m_if_pc4 = m_pc + 4; m_if_instr = ~m_pc; m_valid = 1;
         m_pc = m_pc + 4;
      end
      @(posedge clk);
      #1;
      check("imem_addr", imem_addr, m_pc);
      check("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
      check("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
      check("fetch_count", fetch_count, m_count);
      check("if_pc", if_pc, m_if_pc);
      check("if_pc_plus4", if_pc_plus4, m_if_pc4);
      check("if_instr", if_instr, m_if_instr);
      $display("cyc rst=%0b st=%0b rv=%0b tgt=%08h -> addr=%08h v=%0b pc=%08h flt=%0b cnt=%0d",
               rst, st, rv, tgt, imem_addr, if_valid, if_pc, fetch_fault, fetch_count);
   endtask

   // Monitor: each new delivery (fetch_count advanced with if_valid) pops one record.
   initial begin : monitor
      logic [31:0] last_count;
      fetch_rec_t  e;
      last_count = 32'd0;
      forever begin
         @(posedge clk);
         #1;
         if (!reset && fetch_count != last_count) begin
            if (!if_valid) begin
               check("count_without_valid", {31'd0, if_valid}, 32'd1);
            end else if (exp_q.size() == 0) begin
               check("unexpected_fetch", fetch_count, last_count);
            end else begin
               e = exp_q.pop_front();
               check("sb_if_pc", if_pc, e.pc);
               check("sb_if_pc_plus4", if_pc_plus4, e.pc + 32'd4);
               check("sb_if_instr", if_instr, e.instr);
               check("sb_count", fetch_count, e.count);
            end
         end
         last_count = fetch_count;
      end
   end

   initial begin : driver
      logic [31:0] tgt;
      logic        st, rv, rst;
      int          r;
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      check("reset_addr", imem_addr, 32'h0040_0000);
      // Sequential fetch from reset, then a three-cycle stall at 0x10.
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
      check("stall_pc", imem_addr, 32'h0040_0010);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      check("post_stall_if_pc", if_pc, 32'h0040_0010);
      // Redirect wins over stall.
      step(0, 1, 1, 32'h0040_00D8);
      step(0, 0, 0, 0);
      check("redirect_if_pc", if_pc, 32'h0040_00D8);
      // Last legal word, then falls off the top into HALTED.
      step(0, 0, 1, 32'h0040_03F8);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
      check("top_fault", {31'd0, fetch_fault}, 32'd1);
      // Out-of-range redirect halts; stall is ignored while halted.
      step(0, 0, 1, 32'h0040_0400);
      for (int i = 0; i < 4; i++) step(0, i[0], 0, 0);
      step(0, 0, 1, 32'h0040_0000);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      // Misaligned redirect holds pc at the bad address.
      step(0, 0, 1, 32'h0040_0002);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      check("misaligned_pc", imem_addr, 32'h0040_0002);
      // Reset together with redirect while halted.
      step(1, 1, 1, 32'h0040_0100);
      check("reset_over_redirect", imem_addr, 32'h0040_0000);
      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 99) < 2);
         rv  = ($urandom_range(0, 99) < 10);
         st  = ($urandom_range(0, 99) < 25);
         r   = $urandom_range(0, 9);
         if (r == 0)      tgt = 32'h0040_0400;
         else if (r == 1) tgt = BASE + 32'(4 * $urandom_range(0, WORDS - 1)) + 32'd2;
         else if (r == 2) tgt = 32'h0040_03F0;
         else             tgt = BASE + 32'(4 * $urandom_range(0, WORDS - 1));
         // Stall is never combined with a fetch from an illegal pc.
         if (!m_halted && !legal(m_pc)) st = 0;
         step(rst, st, rv, tgt);
      end
      step(0, 0, 0, 0);
      check("queue_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
